// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: data width, FSM state
// encoding and the serial line idle level.
package uart_pkg;

  localparam int BITWIDTH = 8;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buf_if.sv
// Host-side port bundle of the UART transmitter: write strobe and byte in,
// FIFO status, busy flag and the serial line out.
interface uart_tx_buf_if;
  import uart_pkg::*;

  logic [BITWIDTH-1:0] dataIn;
  logic                WR;
  logic                FULL;
  logic                EMPTY;
  logic                BUSY;
  logic                TxD;

  modport master (output dataIn, output WR,
                  input FULL, input EMPTY, input BUSY, input TxD);
  modport slave  (input dataIn, input WR,
                  output FULL, output EMPTY, output BUSY, output TxD);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Writes while full are dropped;
// flags are decoded from the registered count. DEPTH is a power of 2, >= 2.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                wr,
  input  logic                rd,
  input  logic [BITWIDTH-1:0] din,
  output logic [BITWIDTH-1:0] dout,
  output logic                full,
  output logic                empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BITWIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wr_en, rd_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a pop in the same cycle does not rescue a write.
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge Clk) begin
    if (Rst && wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// UART transmitter: FIFO-buffered bytes serialised as 8N1 frames on TxD.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  uart_tx_buf_if.slave  bus
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e           state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [BITWIDTH-1:0] shift_q, shift_d;
  logic                txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic                pop, bit_end;
  logic [BITWIDTH-1:0] fifo_dout;
  logic                fifo_full, fifo_empty;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .wr    (bus.WR),
    .rd    (pop),
    .din   (bus.dataIn),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.FULL  = fifo_full;
  assign bus.EMPTY = fifo_empty;
  assign bus.BUSY  = (state_q != ST_IDLE);
  assign bus.TxD   = txd_q;

  assign bit_end = (baud_q == BAUD_LAST);

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic, FIFO pop and datapath updates
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = ST_START;
      end
      ST_START: if (bit_end) begin
        state_d   = ST_DATA;
        bit_idx_d = '0;
      end
      ST_DATA: if (bit_end) begin
        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      // Chain straight into the next frame when data is waiting: no idle gap.
      ST_STOP: if (bit_end) begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_dout;
`endif
    end

    // Baud counter restarts on every state entry and at each bit boundary.
    if (state_q == ST_IDLE || state_d != state_q || bit_end) baud_d = '0;
    else                                                       baud_d = baud_q + 1'b1;
  end

  // Output logic: TxD is registered from the next state and next shift contents.
  always_comb begin
    txd_d = IDLE_LEVEL;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = IDLE_LEVEL;
    endcase
  end

endmodule
